// File: rtl/poly1305_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_pkg
// Description : Shared definitions for the Poly1305 stream MAC. Holds the FSM
//               state encoding, the prime p = 2^130-5, the r clamp mask, the
//               list of supported multiplier digit widths and the fold-by-5
//               partial reduction used by both the multiplier and FINAL.
// Revision    : 1.0 - initial release
// ============================================================================
package poly1305_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_ADD    = 3'd2,
        ST_MULT   = 3'd3,
        ST_FINAL  = 3'd4,
        ST_TAG    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // p = 2^130 - 5
    localparam logic [129:0] P = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;

    // Clears r bits 28-31, 60-63, 92-95, 124-127 and 32-33, 64-65, 96-97.
    localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

    // Supported digit widths (each divides 130 exactly); element 0 is 1.
    localparam int N_LEGAL_DIGIT_BITS = 7;
    localparam logic [N_LEGAL_DIGIT_BITS-1:0][6:0] LEGAL_DIGIT_BITS =
        {7'd65, 7'd26, 7'd13, 7'd10, 7'd5, 7'd2, 7'd1};

    // Wide enough for the largest multiplier sum (133 + 65 bits).
    localparam int FOLD_IN_BITS = 200;

    function automatic logic is_legal_digit_bits(input int d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_DIGIT_BITS; i++) begin
            if (int'(LEGAL_DIGIT_BITS[i]) == d) ok = 1'b1;
        end
        return ok;
    endfunction

    // 2^130 == 5 (mod p): bits at and above 130 are multiplied by 5 and
    // added back into the low 130 bits. Callers keep the upper part small
    // enough that the 131-bit result cannot overflow.
    function automatic logic [130:0] fold_by_5(input logic [FOLD_IN_BITS-1:0] x);
        logic [130:0] lo;
        logic [130:0] hi5;
        lo  = {1'b0, x[129:0]};
        hi5 = 131'(x[FOLD_IN_BITS-1:130]) * 131'd5;
        return lo + hi5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly1305_digit_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_digit_multiplier
// Description : One combinational MULT step of the digit-serial h*r product:
//               acc_out = fold(acc_in * 2^DIGIT_BITS + h * digit).
//               With acc_in < 2^131 and h < 2^132 the single fold keeps
//               acc_out < 2^131 for every supported digit width.
// Ports       : h       - accumulated hash operand (h + m), < 2^132
//               digit   - current DIGIT_BITS-wide digit of r, MSB first
//               acc_in  - partial product so far
//               acc_out - partially reduced next partial product
// Revision    : 1.0 - initial release
// ============================================================================
module poly1305_digit_multiplier
    import poly1305_pkg::*;
#(
    parameter int DIGIT_BITS = 13
) (
    input  logic [131:0]            h,
    input  logic [DIGIT_BITS-1:0]   digit,
    input  logic [130:0]            acc_in,
    output logic [130:0]            acc_out
);

    localparam int PROD_BITS = 133 + DIGIT_BITS;

    logic [PROD_BITS-1:0] w_shifted;
    logic [PROD_BITS-1:0] w_partial;
    logic [PROD_BITS-1:0] w_sum;

    assign w_shifted = PROD_BITS'(acc_in) << DIGIT_BITS;
    assign w_partial = PROD_BITS'(h) * PROD_BITS'(digit);
    assign w_sum     = w_shifted + w_partial;
    assign acc_out   = fold_by_5(FOLD_IN_BITS'(w_sum));

endmodule
`default_nettype wire

// File: rtl/poly1305_stream_mac.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_stream_mac
// Description : Block-streaming Poly1305 one-time authenticator. Each 16-byte
//               block is padded, added to h, then multiplied by the clamped r
//               one digit per cycle with partial reduction. After the last
//               block h is fully reduced mod p and s is added to form the tag.
//               clear_n asserts asynchronously; its release must be
//               synchronised to clock by the instantiating level.
// Ports       : clock, clear_n           - clock, async active-low reset
//               start, key               - begin message (IDLE/DONE only)
//               block_valid/ready        - block handshake
//               block_data, block_last,
//               block_bytes_minus_one    - block contents / length of last
//               tag, tag_valid           - result, held until next start
//               busy                     - high outside IDLE and DONE
// Revision    : 1.0 - initial release
// ============================================================================
module poly1305_stream_mac
    import poly1305_pkg::*;
#(
    parameter int DIGIT_BITS = 13
) (
    input  logic            clock,
    input  logic            clear_n,
    input  logic            start,
    input  logic [255:0]    key,
    input  logic            block_valid,
    output logic            block_ready,
    input  logic [127:0]    block_data,
    input  logic [3:0]      block_bytes_minus_one,
    input  logic            block_last,
    output logic [127:0]    tag,
    output logic            tag_valid,
    output logic            busy
);

    localparam int MULT_CYCLES = 130 / DIGIT_BITS;
    localparam int CNT_BITS    = 8;

    generate
        if (!is_legal_digit_bits(DIGIT_BITS)) begin : g_bad_digit_bits
            $error("poly1305_stream_mac: DIGIT_BITS must be one of 1,2,5,10,13,26,65");
        end
    endgenerate

    state_t               r_state;
    logic [127:0]         r_r;
    logic [127:0]         r_s;
    logic [131:0]         r_h;
    logic [128:0]         r_m;
    logic                 r_last;
    logic [130:0]         r_acc;
    logic [129:0]         r_rshift;
    logic [CNT_BITS-1:0]  r_cnt;
    logic [127:0]         r_tag;
    logic                 r_tag_valid;
    logic                 r_block_ready;
    logic                 r_busy;

    logic [128:0]            w_m;
    logic [7:0]              w_pad_shift;
    logic [DIGIT_BITS-1:0]   w_digit;
    logic [130:0]            w_acc_next;
    logic [130:0]            w_fold;
    logic [129:0]            w_reduced;

    // Pad bit sits just above the last valid byte: 2^(8n), n = bytes_minus_one+1.
    assign w_pad_shift = {block_bytes_minus_one, 3'b000} + 8'd8;

    always_comb begin
        w_m = '0;
        for (int i = 0; i < 16; i++) begin
            if (!block_last || (4'(i) <= block_bytes_minus_one)) begin
                w_m[8*i +: 8] = block_data[8*i +: 8];
            end
        end
        if (block_last) begin
            w_m = w_m | (129'd1 << w_pad_shift);
        end else begin
            w_m[128] = 1'b1;
        end
    end

    // r is walked most significant digit first out of a left-shifting copy.
    assign w_digit = r_rshift[129 -: DIGIT_BITS];

    poly1305_digit_multiplier #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_mult (
        .h       (r_h),
        .digit   (w_digit),
        .acc_in  (r_acc),
        .acc_out (w_acc_next)
    );

    // h < 2^131 here, so one fold brings it below 2p and one conditional
    // subtraction completes the reduction.
    assign w_fold    = fold_by_5(FOLD_IN_BITS'(r_h));
    assign w_reduced = (w_fold >= {1'b0, P}) ? 130'(w_fold - {1'b0, P}) : w_fold[129:0];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state       <= ST_IDLE;
            r_r           <= '0;
            r_s           <= '0;
            r_h           <= '0;
            r_m           <= '0;
            r_last        <= 1'b0;
            r_acc         <= '0;
            r_rshift      <= '0;
            r_cnt         <= '0;
            r_tag         <= '0;
            r_tag_valid   <= 1'b0;
            r_block_ready <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_r           <= key[127:0] & CLAMP_MASK;
                        r_s           <= key[255:128];
                        r_h           <= '0;
                        r_tag_valid   <= 1'b0;
                        r_state       <= ST_ABSORB;
                        r_block_ready <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_ABSORB: begin
                    if (block_valid && r_block_ready) begin
                        r_m           <= w_m;
                        r_last        <= block_last;
                        r_state       <= ST_ADD;
                        r_block_ready <= 1'b0;
                    end
                end
                ST_ADD: begin
                    r_h      <= r_h + 132'(r_m);
                    r_acc    <= '0;
                    r_rshift <= {2'b00, r_r};
                    r_cnt    <= '0;
                    r_state  <= ST_MULT;
                end
                ST_MULT: begin
                    r_acc    <= w_acc_next;
                    r_rshift <= r_rshift << DIGIT_BITS;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_BITS'(MULT_CYCLES - 1)) begin
                        r_h           <= 132'(w_acc_next);
                        r_state       <= r_last ? ST_FINAL : ST_ABSORB;
                        r_block_ready <= !r_last;
                    end
                end
                ST_FINAL: begin
                    r_h     <= 132'(w_reduced);
                    r_state <= ST_TAG;
                end
                ST_TAG: begin
                    r_tag       <= r_h[127:0] + r_s;
                    r_tag_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_DONE;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_block_ready <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign block_ready = r_block_ready;
    assign tag         = r_tag;
    assign tag_valid   = r_tag_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_poly1305_stream_mac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_poly1305_stream_mac
// Description : Self-checking bench. One DUT per supported digit width;
//               single-block vectors from a table, multi-block and reset
//               sequences by hand, expected tags queued at start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly1305_stream_mac;

    localparam int N_INST = 7;
    localparam int MAIN   = 4;
    localparam int DBS [N_INST] = '{1, 2, 5, 10, 13, 26, 65};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear_n;
    logic          start_a [N_INST];
    logic [255:0]  key_a   [N_INST];
    logic          bv      [N_INST];
    logic [127:0]  bd      [N_INST];
    logic [3:0]    bmo     [N_INST];
    logic          bl      [N_INST];
    wire           br      [N_INST];
    wire  [127:0]  tag_a   [N_INST];
    wire           tv      [N_INST];
    wire           busy_a  [N_INST];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N_INST; gi++) begin : g_dut
            poly1305_stream_mac #(.DIGIT_BITS(DBS[gi])) u_dut (
                .clock                 (clk),
                .clear_n               (clear_n),
                .start                 (start_a[gi]),
                .key                   (key_a[gi]),
                .block_valid           (bv[gi]),
                .block_ready           (br[gi]),
                .block_data            (bd[gi]),
                .block_bytes_minus_one (bmo[gi]),
                .block_last            (bl[gi]),
                .tag                   (tag_a[gi]),
                .tag_valid             (tv[gi]),
                .busy                  (busy_a[gi])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];
    logic [127:0] prev_exp  [N_INST];
    logic         have_prev [N_INST];

    typedef struct {
        logic [255:0] key;
        logic [127:0] data;
        logic [3:0]   m1;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bound_fail(input string name, input int k);
        n_checks++;
        n_fail++;
        $display("FAIL %s: inst %0d got no response within bound, required a response", name, k);
    endtask

    task automatic do_start(input int k, input logic [255:0] key, input logic [127:0] exp_tag);
        @(negedge clk);
        key_a[k]   = key;
        start_a[k] = 1'b1;
        exp_q.push_back(exp_tag);
        @(negedge clk);
        start_a[k] = 1'b0;
        check("tag_valid_cleared_by_start", 132'(tv[k]), 132'd0);
        check("busy_after_start", 132'(busy_a[k]), 132'd1);
        check("ready_in_absorb", 132'(br[k]), 132'd1);
        if (have_prev[k]) check("tag_holds_after_start", 132'(tag_a[k]), 132'(prev_exp[k]));
    endtask

    task automatic send_block(input int k, input logic [127:0] data, input logic [3:0] m1,
                              input logic last, output int hs);
        int n;
        n = 0;
        bd[k]  = data;
        bmo[k] = m1;
        bl[k]  = last;
        bv[k]  = 1'b1;
        while (br[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        if (br[k] !== 1'b1) begin
            bound_fail("block_ready_timeout", k);
            bv[k] = 1'b0;
        end else begin
            @(negedge clk);
            bv[k] = 1'b0;
            hs = cyc;
            check("ready_low_in_add", 132'(br[k]), 132'd0);
        end
    endtask

    task automatic wait_tag(input int k, input int hs);
        int n;
        logic [127:0] e;
        n = 0;
        while (tv[k] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tv[k] !== 1'b1) begin
            bound_fail("tag_valid_timeout", k);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            check("tag_valid_latency", 132'(cyc - hs), 132'(130 / DBS[k] + 3));
            if (exp_q.size() == 0) begin
                bound_fail("scoreboard_empty", k);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("tag_d%0d", DBS[k]), 132'(tag_a[k]), 132'(e));
                prev_exp[k]  = e;
                have_prev[k] = 1'b1;
            end
            check("busy_low_in_done", 132'(busy_a[k]), 132'd0);
            @(negedge clk);
            check("tag_valid_held", 132'(tv[k]), 132'd1);
            check("tag_held", 132'(tag_a[k]), 132'(prev_exp[k]));
        end
    endtask

    localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] RFC_B0  = 128'h6f4620636968706172676f7470797243;
    localparam logic [127:0] RFC_B1  = 128'h6f7247206863726165736552206d7572;
    localparam logic [127:0] RFC_B2  = 128'h00000000000000000000000000007075;
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [127:0] S44     = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] ONES    = {128{1'b1}};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        clear_n = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            start_a[i] = 1'b0; key_a[i] = '0; bv[i] = 1'b0; bd[i] = '0;
            bmo[i] = '0; bl[i] = 1'b0; prev_exp[i] = '0; have_prev[i] = 1'b1;
        end

        tbl[0] = '{key: {128'h0, 128'h1},  data: 128'h05, m1: 4'd0, exp: 128'h105};
        tbl[1] = '{key: {ONES, 128'h1},    data: 128'h02, m1: 4'd0, exp: 128'h101};
        tbl[2] = '{key: {128'h0, 128'h1},  data: 128'haabb, m1: 4'd0, exp: 128'h1bb};
        tbl[3] = '{key: {128'h0, 128'h1},  data: 128'h00112233445566778899aabbccddeeff,
                   m1: 4'd15, exp: 128'h00112233445566778899aabbccddeeff};
        tbl[4] = '{key: {128'h0, 128'h2},  data: 128'h05, m1: 4'd0, exp: 128'h20a};
        tbl[5] = '{key: {128'h5, 128'h1},  data: ONES, m1: 4'd2, exp: 128'h2000004};
        tbl[6] = '{key: {128'h1234, 128'hf0000003_f0000003_f0000003_f0000000},
                   data: 128'h05, m1: 4'd0, exp: 128'h1234};
        tbl[7] = '{key: {128'h1, 128'h1},  data: 128'hdeadbeef_deadbeef_88776655_44332211,
                   m1: 4'd7, exp: 128'h1_8877665544332212};
        tbl[8] = '{key: {128'h0, 128'h4},  data: ONES, m1: 4'd15, exp: 128'h6};
        tbl[9] = '{key: {128'h0, 128'h1},  data: ONES, m1: 4'd15, exp: ONES};

        #1;
        check("reset_busy", 132'(busy_a[MAIN]), 132'd0);
        check("reset_ready", 132'(br[MAIN]), 132'd0);
        check("reset_tag_valid", 132'(tv[MAIN]), 132'd0);
        check("reset_tag", 132'(tag_a[MAIN]), 132'd0);
        repeat (3) @(negedge clk);
        clear_n = 1'b1;

        // Single-block vectors
        for (int v = 0; v < 10; v++) begin
            do_start(MAIN, tbl[v].key, tbl[v].exp);
            send_block(MAIN, tbl[v].data, tbl[v].m1, 1'b1, hs);
            wait_tag(MAIN, hs);
        end

        // r = 0, three full blocks; a start pulsed mid-MULT must be ignored
        do_start(MAIN, {S44, 128'h0}, S44);
        send_block(MAIN, 128'h1111, 4'd15, 1'b0, hs);
        @(negedge clk);
        check("ready_low_in_mult", 132'(br[MAIN]), 132'd0);
        send_block(MAIN, 128'h2222, 4'd15, 1'b0, hs);
        @(negedge clk);
        key_a[MAIN]   = {128'h0, 128'h1};
        start_a[MAIN] = 1'b1;
        @(negedge clk);
        start_a[MAIN] = 1'b0;
        check("busy_in_mult_after_start", 132'(busy_a[MAIN]), 132'd1);
        send_block(MAIN, 128'h3333, 4'd15, 1'b1, hs);
        wait_tag(MAIN, hs);

        // Reset mid-MULT of block 2, block_valid held in IDLE, then clean restart
        do_start(MAIN, {RFC_S, RFC_R}, 128'h0);
        send_block(MAIN, RFC_B0, 4'd15, 1'b0, hs);
        send_block(MAIN, RFC_B1, 4'd15, 1'b0, hs);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("async_reset_busy", 132'(busy_a[MAIN]), 132'd0);
        check("async_reset_ready", 132'(br[MAIN]), 132'd0);
        check("async_reset_tag_valid", 132'(tv[MAIN]), 132'd0);
        check("async_reset_tag", 132'(tag_a[MAIN]), 132'd0);
        exp_q.delete();
        for (int i = 0; i < N_INST; i++) prev_exp[i] = '0;
        @(negedge clk);
        clear_n = 1'b1;
        bd[MAIN] = 128'h05; bmo[MAIN] = 4'd0; bl[MAIN] = 1'b1; bv[MAIN] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_never_ready", 132'(br[MAIN]), 132'd0);
            check("idle_not_busy", 132'(busy_a[MAIN]), 132'd0);
        end
        bv[MAIN] = 1'b0;
        do_start(MAIN, {128'h0, 128'h1}, 128'h105);
        send_block(MAIN, 128'h05, 4'd0, 1'b1, hs);
        wait_tag(MAIN, hs);

        // RFC 8439 vector on every digit width
        for (int k = 0; k < N_INST; k++) begin
            do_start(k, {RFC_S, RFC_R}, RFC_TAG);
            send_block(k, RFC_B0, 4'd15, 1'b0, hs);
            send_block(k, RFC_B1, 4'd15, 1'b0, hs);
            send_block(k, RFC_B2, 4'd1, 1'b1, hs);
            wait_tag(k, hs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly1305_stream_mac.md
POLY1305_STREAM_MAC -- requirements
Module: poly1305_stream_mac

Interface
REQ-001 SHALL have parameter DIGIT_BITS, default 13, meaning the multiplier digit width; legal values are 1, 2, 5, 10, 13, 26 and 65, and any other value SHALL be rejected at elaboration.
REQ-002 SHALL have derived constant MULT_CYCLES = 130/DIGIT_BITS.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a new message, sampled only in IDLE or DONE.
REQ-006 SHALL have port key, input, 256 bits: r = key[127:0] before clamping, s = key[255:128], little-endian.
REQ-007 SHALL have port block_valid, input, 1 bit: message block offered.
REQ-008 SHALL have port block_ready, output, 1 bit: block accepted on a cycle where block_valid and block_ready are both high.
REQ-009 SHALL have port block_data, input, 128 bits: message byte i in bits [8i+7:8i].
REQ-010 SHALL have port block_bytes_minus_one, input, 4 bits: valid byte count minus one, honoured only when block_last=1.
REQ-011 SHALL have port block_last, input, 1 bit: final block of the message.
REQ-012 SHALL have port tag, output, 128 bits: the message tag, little-endian.
REQ-013 SHALL have port tag_valid, output, 1 bit: tag is valid, held until the next accepted start.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, ABSORB, ADD, MULT, FINAL, TAG and DONE.
REQ-016 On start in IDLE or DONE, SHALL go to ABSORB and latch:
- r clamped by clearing bits 28-31, 60-63, 92-95, 124-127, 32-33, 64-65 and 96-97;
- s;
- h = 0;
- tag_valid = 0.
REQ-017 SHALL ignore start in every other state.
REQ-018 SHALL drive block_ready high only in ABSORB.
REQ-019 SHALL never accept a block in IDLE or DONE.
REQ-020 On handshake, SHALL form the padded block m:
- not last: m = data + 2^128;
- last with n = block_bytes_minus_one+1: m = (data masked to n bytes) + 2^(8n).
REQ-021 SHALL then go to ADD.
REQ-022 ADD (1 cycle) SHALL compute h = h + m, then go to MULT.
REQ-023 MULT SHALL last exactly MULT_CYCLES cycles.
REQ-024 Each MULT cycle SHALL consume the next DIGIT_BITS-bit digit of r, most significant first: acc = acc*2^DIGIT_BITS + h*digit.
REQ-025 Each MULT cycle SHALL partially reduce acc by folding bits at and above 130, multiplied by 5, into the low 130 bits.
REQ-026 The partially reduced acc SHALL satisfy acc < 2^131.
REQ-027 On leaving MULT, SHALL set h = acc, then go to ABSORB if the block was not last, else FINAL.
REQ-028 FINAL (1 cycle) SHALL:
- fold once more, giving h < 2*p, where p = 2^130-5;
- subtract p if h >= p.
REQ-029 TAG (1 cycle) SHALL register tag = (h + s) mod 2^128 and tag_valid = 1, then go to DONE.
REQ-030 tag_valid SHALL rise exactly MULT_CYCLES+3 cycles after the last-block handshake edge (13 cycles for DIGIT_BITS=13).
REQ-031 In DONE, tag and tag_valid SHALL hold until an accepted start.
REQ-032 A start in DONE SHALL clear tag_valid on the following edge; tag holds its old value until overwritten.
REQ-033 A message SHALL contain at least one block; a zero-length message is unsupported.
REQ-034 block_data bits above byte n-1 of a last block SHALL be ignored.
REQ-035 Back-to-back blocks SHALL be accepted with no extra gap beyond MULT_CYCLES+1 cycles per block.

Reset
REQ-036 While clear_n=0, SHALL asynchronously force state=IDLE, h=0, r=0, s=0, tag=0, tag_valid=0, block_ready=0 and busy=0.
REQ-037 Reset asserted mid-message SHALL discard the message; the next start SHALL begin cleanly.
REQ-038 Reset deassertion SHALL be synchronous to clock at the instantiation level.

Structure
REQ-039 A shared package poly1305_pkg SHALL hold:
- the state enum;
- the constants P (130 bits), CLAMP_MASK (128 bits) and the legal DIGIT_BITS list;
- the fold-by-5 reduction function.
REQ-040 One sub-module, poly1305_digit_multiplier, SHALL hold the MULT-phase datapath: operand h, a DIGIT_BITS-wide digit, and acc in/out, combinational.
REQ-041 The FSM, padding, FINAL and TAG logic SHALL remain in poly1305_stream_mac.

Verification
REQ-042 r=1, s=0, one last block 0x05 with bytes_minus_one=0 -> tag=0x105, tag_valid high MULT_CYCLES+3 cycles after the handshake.
REQ-043 r=1, s=2^128-1, one last block 0x02 with bytes_minus_one=0 -> tag=0x101 (carry out of 128 bits dropped).
REQ-044 r=0, s=0x0f0e...0100, three full blocks of any data -> tag=s; block_ready low during ADD/MULT, high in ABSORB.
REQ-045 RFC 8439 §2.5.2 key and message "Cryptographic Forum Research Group" (34 bytes, last block bytes_minus_one=1), run for every legal DIGIT_BITS -> tag equals the RFC published tag.
REQ-046 clear_n pulsed low mid-MULT of block 2, then start plus the REQ-042 stimulus -> tag=0x105; start pulsed during MULT is ignored; block_valid held in IDLE is never accepted.
